cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control FSM that drives the CPU's program counter and gates register write-back.
- Sequences each instruction through FETCH -> EXEC -> WB. Supports free-run and single-step debug, branch-on-zero and halt.
- Sits above the CPU datapath:
  - feeds its `pc` input;
  - consumes the opcode field and the ALU zero flag;
  - qualifies the write-back enable.

Parameters:
- PC_W, 6, program counter width.
- PC_STEP, 2, PC increment per sequential instruction.
- OP_HALT, 6'b111111, opcode that stops the sequencer.
- OP_BEQZ, 6'b111110, opcode: branch to target if ALU zero flag set.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = free-run execution.
- step_req  in  1  single-step request; sampled only in IDLE with run=0.
- step_ack  out  1  one-cycle pulse when a stepped instruction completes WB.
- opcode  in  6  instruction bits [31:26] from instruction memory.
- br_target  in  PC_W  branch target, instruction bits [PC_W-1:0].
- zero  in  1  ALU zero flag.
- dp_reg_write  in  1  write enable from the decoder.
- pc  out  PC_W  current program counter to the datapath.
- wb_en  out  1  qualified register write enable (dp_reg_write AND state==WB AND not halt/branch).
- halted  out  1  high while in HALT.
- state  out  3  encoded FSM state, for debug.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- **Reset (async, immediate):**
  - pc=0, state=IDLE, wb_en=0, step_ack=0, halted=0, retired=0;
  - internal latches zero: zero_q, opcode_q, br_target_q (and the step-mode flag).
- **States:** IDLE=0, FETCH=1, EXEC=2, WB=3, HALT=4.
- **IDLE:**
  - run=1 -> FETCH.
  - Else if step_req=1 -> FETCH, and mark step mode.
  - run=1 and step_req=1 together: run wins; step mode is not set and no step_ack is produced.
- **FETCH:** pc held stable; instruction memory is combinational. -> EXEC next cycle.
- **EXEC:**
  - Latch opcode_q, zero_q, br_target_q.
  - opcode==OP_HALT -> HALT. pc unchanged, retired unchanged, no write-back.
  - Otherwise -> WB.
- **WB (exactly one cycle):**
  - wb_en = dp_reg_write, except forced 0 when opcode_q==OP_BEQZ.
  - Next pc:
    - OP_BEQZ with zero_q=1 -> br_target_q;
    - otherwise (pc + PC_STEP) mod 2^PC_W, so 62 -> 0.
  - retired increments, saturating at all-ones.
  - step_ack pulses if in step mode; step mode then clears.
  - Exit: run=1 and not step mode -> FETCH; otherwise -> IDLE.
- **Latency:** 3 cycles per instruction; pc changes on the clock edge ending WB.
- **run deasserted mid-instruction:** the current instruction completes through WB, then IDLE. No partial instruction is ever abandoned.
- **step_req outside IDLE, or while run=1:** ignored. Requests are not queued.
- **HALT:** terminal; only reset exits. halted=1, wb_en=0; run and step_req are ignored.
- **Reset mid-WB:** wb_en drops asynchronously; no write occurs on the following edge.
- **Outputs:** all registered except wb_en, which is combinational from state, opcode_q and dp_reg_write.

Decomposition:
- **Shared package `cpu_pkg`:**
  - state enum (IDLE/FETCH/EXEC/WB/HALT);
  - OP_HALT, OP_BEQZ, PC_W, PC_STEP;
  - the opcode field slice positions. The decoder and ALU reuse these opcode constants.
- **Sub-module `pc_next`:** combinational next-PC selection (increment-with-wrap vs. branch target).
- Single FSM in the top module; no further hierarchy.

Test Plan:
1. **Reset, then free-run:** reset, run=1, three non-branch ops with dp_reg_write=1 -> pc 0,2,4,6 at 3-cycle spacing; wb_en high exactly one cycle per instruction; retired=3.
2. **Branch:** BEQZ at pc=4 with br_target=20:
   - zero=1 -> pc=20 after WB, wb_en=0;
   - repeat with zero=0 -> pc=6.
3. **Single step:** run=0, step_req pulse -> one instruction executes; step_ack pulses once in WB cycle; state returns IDLE; further cycles leave pc unchanged.
4. **Wrap and halt:**
   - pc=62 non-branch -> pc=0;
   - then OP_HALT -> halted=1, pc stays 0, retired unchanged, run/step_req ignored for 10 cycles.
5. **Mid-instruction events:**
   - run dropped during EXEC -> WB still completes, then IDLE;
   - run=1 and step_req=1 simultaneously in IDLE -> no step_ack.
6. **Async reset during WB:** assert reset mid-cycle -> wb_en=0 immediately; pc=0, retired=0, state=IDLE before next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared CPU control constants: sequencer state encoding,
//             special opcodes, PC geometry and the instruction opcode field.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Program counter geometry
    localparam int PC_W    = 6;
    localparam int PC_STEP = 2;

    // Retired-instruction counter width
    localparam int CNT_W   = 16;

    // Opcode field position within a 32-bit instruction word
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    // Special opcodes understood by the sequencer (decoder/ALU reuse these)
    localparam logic [OPCODE_W-1:0] OP_HALT = 6'b111111;
    localparam logic [OPCODE_W-1:0] OP_BEQZ = 6'b111110;

    // Sequencer state encoding, exported on the debug state port
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_sequencer_pc_next.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next
//  Brief    : Combinational next-PC selection: sequential increment with
//             natural wrap, or the branch target when a branch is taken.
//  Revision : 1.0  initial release
// ============================================================================
module pc_next #(
    parameter int PC_W    = 6,
    parameter int PC_STEP = 2
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] br_target,
    input  logic            take_branch,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] w_inc_pc;

    // Truncation to PC_W bits gives the modulo-2^PC_W wrap (e.g. 62 -> 0)
    assign w_inc_pc = pc + PC_W'(PC_STEP);

    // Select branch target or sequential successor
    always_comb begin
        next_pc = w_inc_pc;
        if (take_branch) begin
            next_pc = br_target;
        end
    end

endmodule : pc_next
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sequencer
//  Brief    : Multi-cycle FETCH -> EXEC -> WB control FSM. Owns the program
//             counter, qualifies register write-back, supports free-run,
//             single-step, branch-on-zero and a terminal HALT state.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_sequencer #(
    parameter int          PC_W    = cpu_pkg::PC_W,
    parameter int          PC_STEP = cpu_pkg::PC_STEP,
    parameter logic [5:0]  OP_HALT = cpu_pkg::OP_HALT,
    parameter logic [5:0]  OP_BEQZ = cpu_pkg::OP_BEQZ,
    parameter int          CNT_W   = cpu_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step_req,
    output logic             step_ack,
    input  logic [5:0]       opcode,
    input  logic [PC_W-1:0]  br_target,
    input  logic             zero,
    input  logic             dp_reg_write,
    output logic [PC_W-1:0]  pc,
    output logic             wb_en,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    import cpu_pkg::*;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_state_nxt;

    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_next_pc;
    logic [CNT_W-1:0]  r_retired;
    logic              r_step_mode;
    logic              r_step_ack;
    logic              r_halted;
    logic [5:0]        r_opcode_q;
    logic              r_zero_q;
    logic [PC_W-1:0]   r_br_target_q;

    logic              w_enter_step;
    logic              w_latch;
    logic              w_commit;
    logic              w_take_branch;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; WB always lasts exactly one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run || step_req) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (opcode == OP_HALT) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_WB: begin
                if (run && !r_step_mode) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-state control strobes and the combinational write-back qualifier
    always_comb begin
        w_enter_step = 1'b0;
        w_latch      = 1'b0;
        w_commit     = 1'b0;
        wb_en        = 1'b0;
        case (r_state)
            // run has priority, so a simultaneous step request is not a step
            ST_IDLE:  w_enter_step = !run && step_req;
            ST_EXEC:  w_latch      = 1'b1;
            ST_WB: begin
                w_commit = 1'b1;
                wb_en    = dp_reg_write && (r_opcode_q != OP_BEQZ);
            end
            default: begin
                w_commit = 1'b0;
            end
        endcase
    end

    assign w_take_branch = (r_opcode_q == OP_BEQZ) && r_zero_q;

    pc_next #(
        .PC_W    (PC_W),
        .PC_STEP (PC_STEP)
    ) u_pc_next (
        .pc          (r_pc),
        .br_target   (r_br_target_q),
        .take_branch (w_take_branch),
        .next_pc     (w_next_pc)
    );

    // Datapath-side registers: operand latches, PC, retire counter, flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= '0;
            r_retired     <= '0;
            r_step_mode   <= 1'b0;
            r_step_ack    <= 1'b0;
            r_halted      <= 1'b0;
            r_opcode_q    <= '0;
            r_zero_q      <= 1'b0;
            r_br_target_q <= '0;
        end else begin
            // step_ack is raised on entry to WB so it is high during WB only
            r_step_ack <= 1'b0;
            if (w_enter_step) begin
                r_step_mode <= 1'b1;
            end
            if (w_latch) begin
                r_opcode_q    <= opcode;
                r_zero_q      <= zero;
                r_br_target_q <= br_target;
                if (opcode == OP_HALT) begin
                    r_halted <= 1'b1;
                end else begin
                    r_step_ack <= r_step_mode;
                end
            end
            if (w_commit) begin
                r_pc        <= w_next_pc;
                r_step_mode <= 1'b0;
                if (r_retired != C_CNT_MAX) begin
                    r_retired <= r_retired + CNT_W'(1);
                end
            end
        end
    end

    assign pc       = r_pc;
    assign retired  = r_retired;
    assign step_ack = r_step_ack;
    assign halted   = r_halted;
    assign state    = r_state;

endmodule : cpu_sequencer
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_sequencer
//  Brief    : Directed self-checking bench for cpu_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;

    localparam logic [5:0] C_HALT = 6'b111111;
    localparam logic [5:0] C_BEQZ = 6'b111110;
    localparam logic [5:0] C_NOP  = 6'b000000;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step_req;
    logic        step_ack;
    logic [5:0]  opcode;
    logic [5:0]  br_target;
    logic        zero;
    logic        dp_reg_write;
    logic [5:0]  pc;
    logic        wb_en;
    logic        halted;
    logic [2:0]  state;
    logic [15:0] retired;

    int errors = 0;
    int checks = 0;

    // Observations captured by run_one during the WB cycle
    logic       wb_seen;
    logic       ack_seen;
    logic [2:0] st_seen;

    cpu_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .step_req     (step_req),
        .step_ack     (step_ack),
        .opcode       (opcode),
        .br_target    (br_target),
        .zero         (zero),
        .dp_reg_write (dp_reg_write),
        .pc           (pc),
        .wb_en        (wb_en),
        .halted       (halted),
        .state        (state),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; observations and new drives happen 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        run          = 1'b0;
        step_req     = 1'b0;
        opcode       = C_NOP;
        br_target    = '0;
        zero         = 1'b0;
        dp_reg_write = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One free-run instruction from IDLE, with run released after FETCH
    task automatic run_one(input logic [5:0] op, input logic z,
                           input logic [5:0] tgt, input logic dpw);
        opcode       = op;
        zero         = z;
        br_target    = tgt;
        dp_reg_write = dpw;
        run          = 1'b1;
        tick();                 // FETCH
        run = 1'b0;
        tick();                 // EXEC
        tick();                 // WB
        wb_seen  = wb_en;
        ack_seen = step_ack;
        st_seen  = state;
        tick();                 // IDLE
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run = 1'b0; step_req = 1'b0; opcode = C_NOP;
        br_target = '0; zero = 1'b0; dp_reg_write = 1'b1;
        tick();
        checks++;
        if (pc !== 6'd0 || state !== 3'd0 || wb_en !== 1'b0 || step_ack !== 1'b0 ||
            halted !== 1'b0 || retired !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: pc=%0d state=%0d wb_en=%b ack=%b halted=%b retired=%0d, want all 0",
                     pc, state, wb_en, step_ack, halted, retired);
        end
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        int wb_count;
        int exp_state;
        int exp_pc;
        wb_count = 0;
        do_reset();
        run = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_state = ((k - 1) % 3) + 1;
            exp_pc    = 2 * ((k - 1) / 3);
            checks++;
            if (state !== exp_state[2:0] || pc !== exp_pc[5:0] || wb_en !== ((k % 3) == 0)) begin
                errors++;
                $display("FAIL free_run_cycle%0d: state=%0d pc=%0d wb_en=%b, want state=%0d pc=%0d wb_en=%b",
                         k, state, pc, wb_en, exp_state, exp_pc, (k % 3) == 0);
            end
            if (wb_en === 1'b1) wb_count++;
        end
        run = 1'b0;
        tick();
        checks++;
        if (wb_count != 3 || state !== 3'd0 || pc !== 6'd6 || retired !== 16'd3) begin
            errors++;
            $display("FAIL free_run_end: wb_cycles=%0d state=%0d pc=%0d retired=%0d, want 3 0 6 3",
                     wb_count, state, pc, retired);
        end
    endtask

    task automatic test_branch();
        do_reset();
        run_one(C_NOP, 1'b0, 6'd0, 1'b1);
        run_one(C_NOP, 1'b0, 6'd0, 1'b1);
        checks++;
        if (pc !== 6'd4) begin
            errors++;
            $display("FAIL branch_setup: pc=%0d, want 4", pc);
        end
        run_one(C_BEQZ, 1'b1, 6'd20, 1'b1);
        checks++;
        if (pc !== 6'd20 || wb_seen !== 1'b0 || retired !== 16'd3) begin
            errors++;
            $display("FAIL branch_taken: pc=%0d wb_en=%b retired=%0d, want 20 0 3", pc, wb_seen, retired);
        end
        do_reset();
        run_one(C_NOP, 1'b0, 6'd0, 1'b1);
        run_one(C_NOP, 1'b0, 6'd0, 1'b1);
        run_one(C_BEQZ, 1'b0, 6'd20, 1'b1);
        checks++;
        if (pc !== 6'd6 || wb_seen !== 1'b0) begin
            errors++;
            $display("FAIL branch_not_taken: pc=%0d wb_en=%b, want 6 0", pc, wb_seen);
        end
    endtask

    task automatic test_single_step();
        int acks;
        acks = 0;
        // pc is 6, IDLE, after test_branch
        opcode = C_NOP; dp_reg_write = 1'b1; run = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL step_start: state=%0d, want 1", state);
        end
        if (step_ack === 1'b1) acks++;
        tick();
        if (step_ack === 1'b1) acks++;
        tick();
        checks++;
        if (state !== 3'd3 || step_ack !== 1'b1 || wb_en !== 1'b1) begin
            errors++;
            $display("FAIL step_wb: state=%0d ack=%b wb_en=%b, want 3 1 1", state, step_ack, wb_en);
        end
        if (step_ack === 1'b1) acks++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (step_ack === 1'b1) acks++;
        end
        checks++;
        if (state !== 3'd0 || pc !== 6'd8 || acks != 1 || retired !== 16'd4) begin
            errors++;
            $display("FAIL step_end: state=%0d pc=%0d acks=%0d retired=%0d, want 0 8 1 4",
                     state, pc, acks, retired);
        end
    endtask

    task automatic test_wrap_halt();
        do_reset();
        run_one(C_BEQZ, 1'b1, 6'd62, 1'b1);
        checks++;
        if (pc !== 6'd62) begin
            errors++;
            $display("FAIL wrap_setup: pc=%0d, want 62", pc);
        end
        run_one(C_NOP, 1'b0, 6'd0, 1'b1);
        checks++;
        if (pc !== 6'd0 || retired !== 16'd2) begin
            errors++;
            $display("FAIL wrap: pc=%0d retired=%0d, want 0 2", pc, retired);
        end
        opcode = C_HALT; run = 1'b1; dp_reg_write = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (state !== 3'd4 || halted !== 1'b1 || pc !== 6'd0 || retired !== 16'd2 || wb_en !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter: state=%0d halted=%b pc=%0d retired=%0d wb_en=%b, want 4 1 0 2 0",
                     state, halted, pc, retired, wb_en);
        end
        opcode = C_NOP;
        for (int i = 0; i < 10; i++) begin
            run      = 1'b1;
            step_req = i[0];
            tick();
            checks++;
            if (state !== 3'd4 || halted !== 1'b1 || pc !== 6'd0 || retired !== 16'd2 || wb_en !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold%0d: state=%0d halted=%b pc=%0d retired=%0d wb_en=%b, want 4 1 0 2 0",
                         i, state, halted, pc, retired, wb_en);
            end
        end
        run = 1'b0; step_req = 1'b0;
    endtask

    task automatic test_mid_instruction();
        do_reset();
        run = 1'b1;
        tick();                 // FETCH
        tick();                 // EXEC
        run = 1'b0;
        tick();                 // WB
        checks++;
        if (state !== 3'd3 || wb_en !== 1'b1) begin
            errors++;
            $display("FAIL run_drop_wb: state=%0d wb_en=%b, want 3 1", state, wb_en);
        end
        tick();
        checks++;
        if (state !== 3'd0 || pc !== 6'd2 || retired !== 16'd1) begin
            errors++;
            $display("FAIL run_drop_end: state=%0d pc=%0d retired=%0d, want 0 2 1", state, pc, retired);
        end
        run = 1'b1; step_req = 1'b1;
        tick();                 // FETCH
        run = 1'b0; step_req = 1'b0;
        tick();                 // EXEC
        tick();                 // WB
        checks++;
        if (state !== 3'd3 || step_ack !== 1'b0) begin
            errors++;
            $display("FAIL run_and_step: state=%0d ack=%b, want 3 0", state, step_ack);
        end
        tick();
        checks++;
        if (state !== 3'd0 || pc !== 6'd4 || step_ack !== 1'b0) begin
            errors++;
            $display("FAIL run_and_step_end: state=%0d pc=%0d ack=%b, want 0 4 0", state, pc, step_ack);
        end
    endtask

    task automatic test_async_reset_wb();
        do_reset();
        run_one(C_NOP, 1'b0, 6'd0, 1'b1);
        run = 1'b1;
        tick();                 // FETCH
        run = 1'b0;
        tick();                 // EXEC
        tick();                 // WB
        checks++;
        if (state !== 3'd3 || wb_en !== 1'b1 || pc !== 6'd2 || retired !== 16'd1) begin
            errors++;
            $display("FAIL areset_pre: state=%0d wb_en=%b pc=%0d retired=%0d, want 3 1 2 1",
                     state, wb_en, pc, retired);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (wb_en !== 1'b0 || pc !== 6'd0 || retired !== 16'd0 || state !== 3'd0) begin
            errors++;
            $display("FAIL areset_mid_wb: wb_en=%b pc=%0d retired=%0d state=%0d, want 0 0 0 0",
                     wb_en, pc, retired, state);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (state !== 3'd0 || pc !== 6'd0 || retired !== 16'd0) begin
            errors++;
            $display("FAIL areset_after: state=%0d pc=%0d retired=%0d, want 0 0 0", state, pc, retired);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_branch();
        test_single_step();
        test_wrap_halt();
        test_mid_instruction();
        test_async_reset_wb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cpu_sequencer
`default_nettype wire
